// File: rtl/down_counter.sv
// Loadable WIDTH-bit countdown timer with a one-cycle terminal-count pulse.
// Runs one-shot, or reloads itself on terminal count when AUTO_RELOAD is set.
module down_counter #(
    parameter int WIDTH       = 8,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc,
    output logic             zero
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_VAL  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_s;
    logic [WIDTH-1:0] reload_r;
    logic [WIDTH-1:0] reload_s;
    logic             busy_r;
    logic             busy_s;
    logic             tc_r;
    logic             tc_s;

    // Next-state decode: load beats the terminal event, which beats a plain decrement.
    always_comb begin
        state_s  = state_r;
        count_s  = count_r;
        reload_s = reload_r;
        tc_s     = 1'b0;
        if (load) begin
            count_s  = load_val;
            reload_s = load_val;
            if (load_val != ZERO_VAL) begin
                state_s = ST_RUN;
            end else begin
                state_s = ST_IDLE;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s = ST_IDLE;
                end
                ST_RUN: begin
                    if (!en) begin
                        state_s = ST_RUN;
                    end else if (count_r == ONE_VAL) begin
                        tc_s = 1'b1;
                        if (AUTO_RELOAD) begin
                            count_s = reload_r;
                        end else begin
                            count_s = ZERO_VAL;
                            state_s = ST_DONE;
                        end
                    end else if (count_r != ZERO_VAL) begin
                        // The zero guard keeps the counter from ever wrapping.
                        count_s = count_r - ONE_VAL;
                    end else begin
                        count_s = count_r;
                    end
                end
                ST_DONE: begin
                    count_s = ZERO_VAL;
                end
                default: begin
                    state_s = ST_IDLE;
                    count_s = ZERO_VAL;
                end
            endcase
        end
        busy_s = (state_s == ST_RUN);
    end

    // State, count, reload value and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            count_r  <= ZERO_VAL;
            reload_r <= ZERO_VAL;
            busy_r   <= 1'b0;
            tc_r     <= 1'b0;
        end else begin
            state_r  <= state_s;
            count_r  <= count_s;
            reload_r <= reload_s;
            busy_r   <= busy_s;
            tc_r     <= tc_s;
        end
    end

    assign count = count_r;
    assign busy  = busy_r;
    assign tc    = tc_r;
    assign zero  = (count_r == ZERO_VAL);

endmodule
